// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module : io_port_bridge
// Desc   : Input and output word FIFOs between the processor I/O pins and
//          external producer/consumer handshakes, with sticky error flags.
// Rev    : 1.0
// ============================================================================
module io_port_bridge #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] read_in,
    output logic             in_avail,
    input  logic             cpu_rd,
    input  logic [WIDTH-1:0] write_out,
    input  logic             cpu_wr,
    output logic             out_full,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready,
    input  logic             err_clr,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

    // Index 0 is the input FIFO, index 1 the output FIFO.
    logic             w_push_req [2];
    logic             w_pop_req  [2];
    logic [WIDTH-1:0] w_wdata    [2];
    logic [WIDTH-1:0] w_head     [2];
    logic             w_full     [2];
    logic             w_empty    [2];

    assign w_push_req[0] = ext_in_valid;
    assign w_pop_req[0]  = cpu_rd;
    assign w_wdata[0]    = ext_in_data;
    assign w_push_req[1] = cpu_wr;
    assign w_pop_req[1]  = ext_out_ready;
    assign w_wdata[1]    = write_out;

    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [c_AW-1:0]  r_rd_ptr;
        logic [c_AW-1:0]  r_wr_ptr;
        logic [c_CW-1:0]  r_count;
        logic             w_push;
        logic             w_pop;

        // Full/empty come from the current count only, so a full FIFO refuses
        // a push even when it is popped on the same edge.
        assign w_full[f]  = (r_count == c_CNT_FULL);
        assign w_empty[f] = (r_count == '0);
        assign w_push     = w_push_req[f] && !w_full[f];
        assign w_pop      = w_pop_req[f] && !w_empty[f];
        assign w_head[f]  = w_empty[f] ? '0 : r_mem[r_rd_ptr];

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end

        // Storage is left unreset; an empty FIFO masks its head to zero.
        always_ff @(posedge clock) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wdata[f];
            end
        end
    end

    assign ext_in_ready  = !w_full[0];
    assign in_avail      = !w_empty[0];
    assign read_in       = w_head[0];
    assign out_full      = w_full[1];
    assign ext_out_valid = !w_empty[1];
    assign ext_out_data  = w_head[1];

    logic w_underflow_evt;
    logic w_overflow_evt;
    logic r_err_underflow;
    logic r_err_overflow;

    assign w_underflow_evt = cpu_rd && w_empty[0];
    assign w_overflow_evt  = cpu_wr && w_full[1];

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_err_underflow <= w_underflow_evt || (r_err_underflow && !err_clr);
            r_err_overflow  <= w_overflow_evt  || (r_err_overflow  && !err_clr);
        end
    end

    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_io_port_bridge
// Desc   : Scoreboard bench for io_port_bridge: directed scenarios plus random
//          traffic checked against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_io_port_bridge;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [WIDTH-1:0] ext_in_data   = '0;
    logic             ext_in_valid  = 1'b0;
    logic             ext_in_ready;
    logic [WIDTH-1:0] read_in;
    logic             in_avail;
    logic             cpu_rd        = 1'b0;
    logic [WIDTH-1:0] write_out     = '0;
    logic             cpu_wr        = 1'b0;
    logic             out_full;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready = 1'b0;
    logic             err_clr       = 1'b0;
    logic             err_underflow;
    logic             err_overflow;

    always #5 clock = ~clock;

    io_port_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock        (clock),
        .rst          (rst),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .read_in      (read_in),
        .in_avail     (in_avail),
        .cpu_rd       (cpu_rd),
        .write_out    (write_out),
        .cpu_wr       (cpu_wr),
        .out_full     (out_full),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready),
        .err_clr      (err_clr),
        .err_underflow(err_underflow),
        .err_overflow (err_overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: occupancies and flags for the current cycle (m_*) and
    // for after the coming edge (nx_*); queues hold the expected word order.
    int               m_in_cnt, m_out_cnt, nx_in_cnt, nx_out_cnt;
    bit               m_uf, m_of, nx_uf, nx_of;
    logic [WIDTH-1:0] exp_in[$];
    logic [WIDTH-1:0] exp_out[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_in_cnt = 0; m_out_cnt = 0; nx_in_cnt = 0; nx_out_cnt = 0;
        m_uf = 0; m_of = 0; nx_uf = 0; nx_of = 0;
        exp_in.delete();
        exp_out.delete();
    endtask

    // One cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic step(input bit iv, input logic [WIDTH-1:0] id, input bit rd,
                        input bit wr, input logic [WIDTH-1:0] wd, input bit ordy,
                        input bit clr);
        bit in_push, in_pop, out_push, out_pop;
        @(posedge clock);
        #1;
        m_in_cnt = nx_in_cnt; m_out_cnt = nx_out_cnt; m_uf = nx_uf; m_of = nx_of;
        ext_in_valid = iv; ext_in_data = id; cpu_rd = rd;
        cpu_wr = wr; write_out = wd; ext_out_ready = ordy; err_clr = clr;
        in_push  = iv && (m_in_cnt < DEPTH);
        in_pop   = rd && (m_in_cnt > 0);
        out_push = wr && (m_out_cnt < DEPTH);
        out_pop  = ordy && (m_out_cnt > 0);
        if (in_push)  exp_in.push_back(id);
        if (out_push) exp_out.push_back(wd);
        nx_in_cnt  = m_in_cnt + int'(in_push) - int'(in_pop);
        nx_out_cnt = m_out_cnt + int'(out_push) - int'(out_pop);
        nx_uf = (rd && m_in_cnt == 0) ? 1'b1 : (clr ? 1'b0 : m_uf);
        nx_of = (wr && m_out_cnt == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_of);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, 0, 0);
    endtask

    // Monitor: status against model occupancy, head words against the
    // scoreboard queues, popping whenever the DUT completes a transfer.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("ext_in_ready", ext_in_ready, m_in_cnt != DEPTH);
            chk("in_avail", in_avail, m_in_cnt != 0);
            chk("out_full", out_full, m_out_cnt == DEPTH);
            chk("ext_out_valid", ext_out_valid, m_out_cnt != 0);
            chk("err_underflow", err_underflow, m_uf);
            chk("err_overflow", err_overflow, m_of);
            if (m_in_cnt == 0) begin
                chk("read_in_empty", read_in, 0);
            end else if (exp_in.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL read_in_sb: got %0h expected nothing queued", read_in);
            end else begin
                chk("read_in_head", read_in, exp_in[0]);
            end
            if (m_out_cnt == 0) begin
                chk("ext_out_data_empty", ext_out_data, 0);
            end else if (exp_out.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL ext_out_sb: got %0h expected nothing queued", ext_out_data);
            end else begin
                chk("ext_out_data_head", ext_out_data, exp_out[0]);
            end
            if (in_avail && cpu_rd && exp_in.size() > 0) void'(exp_in.pop_front());
            if (ext_out_valid && ext_out_ready && exp_out.size() > 0) void'(exp_out.pop_front());
        end
    end

    initial begin
        model_clear();
        #12;
        chk("rst_read_in", read_in, 0);
        chk("rst_ext_in_ready", ext_in_ready, 1);
        chk("rst_ext_out_valid", ext_out_valid, 0);
        @(posedge clock);
        #3;
        rst = 1'b0;
        chk_en = 1'b1;

        // Asynchronous reset with two words in each FIFO.
        step(1, 16'h0101, 0, 1, 16'h0202, 0, 0);
        step(1, 16'h0303, 0, 1, 16'h0404, 0, 0);
        idle();
        #2;
        chk("pre_rst_in_avail", in_avail, 1);
        chk("pre_rst_out_valid", ext_out_valid, 1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_read_in", read_in, 0);
        chk("async_rst_in_ready", ext_in_ready, 1);
        chk("async_rst_in_avail", in_avail, 0);
        chk("async_rst_out_valid", ext_out_valid, 0);
        chk("async_rst_out_data", ext_out_data, 0);
        chk("async_rst_out_full", out_full, 0);
        model_clear();
        @(posedge clock);
        #3;
        rst = 1'b0;
        chk_en = 1'b1;

        // Input fill, refusal, ordered drain.
        for (int i = 0; i < 4; i++) step(1, WIDTH'(16'h1111 * (i + 1)), 0, 0, '0, 0, 0);
        step(1, 16'h5555, 0, 0, '0, 0, 0);
        chk("fill_in_ready_low", ext_in_ready, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, '0, 0, 0);
        idle();
        idle();

        // Output backpressure, overflow drop, ordered drain.
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, WIDTH'(16'hA001 + i), 0, 0);
        step(0, '0, 0, 1, 16'hA005, 0, 0);
        idle();
        idle();
        for (int i = 0; i < 5; i++) step(0, '0, 0, 0, '0, 1, 0);
        step(0, '0, 0, 0, '0, 0, 1);
        idle();

        // Simultaneous push/pop at count 2, then push with read on empty.
        step(1, 16'hC001, 0, 0, '0, 0, 0);
        step(1, 16'hC002, 0, 0, '0, 0, 0);
        step(1, 16'hC003, 1, 0, '0, 0, 0);
        idle();
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0);
        idle();
        step(1, 16'hBEEF, 1, 0, '0, 0, 0);
        idle();
        step(0, '0, 1, 0, '0, 0, 1);
        idle();

        // Streaming across the pointer wrap on both FIFOs.
        for (int i = 0; i < 10; i++) step(1, WIDTH'(i), i > 0, 1, WIDTH'(i), i > 0, 0);
        step(0, '0, 1, 0, '0, 1, 0);
        idle();

        // Sticky error flag clear, and set winning over clear.
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 0, 0, '0, 0, 1);
        idle();
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 1);
        idle();
        step(0, '0, 0, 0, '0, 0, 1);
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, WIDTH'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, WIDTH'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
        end
        idle();
        idle();
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_port_bridge.md
# io_port_bridge

Word-wide I/O bridge on the far side of the processor's `read_in` / `write_out` pins. Buffers words arriving from an external producer in an input FIFO and presents the head word on `read_in`. Captures words the processor emits on `write_out` into an output FIFO and drains them to an external consumer over a valid/ready handshake. Sits at the top level beside the processor and is the only path between the core and off-core I/O.

## Interface
- `DEPTH`, 4, entries per FIFO; power of two, at least 2
- `WIDTH`, 16, data word width; matches the processor datapath

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `ext_in_data`  in  WIDTH  word from the external producer
- `ext_in_valid`  in  1  producer has a word
- `ext_in_ready`  out  1  input FIFO not full
- `read_in`  out  WIDTH  input FIFO head word; 0 when empty; drives the processor's `read_in`
- `in_avail`  out  1  input FIFO non-empty
- `cpu_rd`  in  1  processor consumed `read_in`; pops the input FIFO
- `write_out`  in  WIDTH  word from the processor's `write_out`
- `cpu_wr`  in  1  processor is writing `write_out`; pushes the output FIFO
- `out_full`  out  1  output FIFO full
- `ext_out_data`  out  WIDTH  output FIFO head word; 0 when empty
- `ext_out_valid`  out  1  output FIFO non-empty
- `ext_out_ready`  in  1  consumer accepts a word
- `err_clr`  in  1  clears both sticky error flags
- `err_underflow`  out  1  sticky; `cpu_rd` seen while the input FIFO was empty
- `err_overflow`  out  1  sticky; `cpu_wr` seen while the output FIFO was full

## Operation
- There are two independent circular FIFOs. Each has `DEPTH` storage words, a read pointer and a write pointer of log2(`DEPTH`) bits that wrap modulo `DEPTH`, and an occupancy count of log2(`DEPTH`)+1 bits.
- Input FIFO push happens when `ext_in_valid && ext_in_ready`.
- Input FIFO pop happens when `cpu_rd && in_avail`.
- Output FIFO push happens when `cpu_wr && !out_full`.
- Output FIFO pop happens when `ext_out_valid && ext_out_ready`.
- Full and empty are derived from the count: full means count == `DEPTH`; empty means count == 0.
- Simultaneous push and pop on a FIFO that is neither empty nor full: both take effect and the count is unchanged.
- Full FIFO: a push is refused even if a pop occurs in the same cycle. The ready/full signal is based on the current count only, with no same-cycle bypass.
- Empty FIFO: a pop is ignored. A push in the same cycle is accepted normally.
- `cpu_rd` on an empty input FIFO sets `err_underflow`. No pointer moves.
- `cpu_wr` on a full output FIFO sets `err_overflow`. The word is dropped and no pointer moves.
- Error flags are sticky until `err_clr` or `rst`. If `err_clr` and a new error event occur in the same cycle, the flag remains set (set wins).
- The head outputs (`read_in`, `ext_out_data`) come from the registered storage. Each is forced to 0 when its FIFO is empty.
- Storage contents are not reset. Only pointers, counts and flags are reset.

## Timing
- Reset values, asserted asynchronously and held until the first edge after `rst` falls:
  - pointers and counts are 0
  - `ext_in_ready` = 1, `in_avail` = 0, `read_in` = 0
  - `out_full` = 0, `ext_out_valid` = 0, `ext_out_data` = 0
  - `err_underflow` = 0, `err_overflow` = 0
- Latency is one edge, end to end:
  - A word accepted at edge k appears on `read_in` (or `ext_out_data`) in the cycle after edge k.
  - A word popped at edge k is replaced by the next entry, or by 0, after edge k.
- Status outputs `ext_in_ready`, `in_avail`, `out_full` and `ext_out_valid` are decoded from registered counts. They therefore change only after a clock edge, or on `rst`.
- Handshake rules:
  - `ext_out_valid`, once high, stays high with `ext_out_data` stable until accepted.
  - The producer may deassert `ext_in_valid` freely.
  - `cpu_rd` and `cpu_wr` are single-cycle strobes. Holding either for N cycles performs N operations.
- Reset mid-operation (`rst` asserted with data in flight) empties both FIFOs immediately. Words stored but not yet drained are lost.
- Pointer wrap: after `DEPTH` pushes the write pointer returns to 0. FIFO order is preserved across the wrap.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle with 2 words in each FIFO -> all outputs take their reset values at once (`read_in`=0, `ext_in_ready`=1, `ext_out_valid`=0) without waiting for a clock edge.
- Input order, fill and refusal: push 0x1111, 0x2222, 0x3333, 0x4444 (DEPTH=4) -> `ext_in_ready`=0 after the 4th edge. Then a 5th push of 0x5555 is refused. Four `cpu_rd` strobes then yield `read_in` = 0x1111, 0x2222, 0x3333, 0x4444, after which `read_in`=0 and `in_avail`=0.
- Output backpressure: hold `ext_out_ready`=0 and write 0xA001–0xA004 via `cpu_wr` -> `out_full`=1. A 5th `cpu_wr` of 0xA005 sets `err_overflow`=1 and is dropped. Releasing `ext_out_ready` drains 0xA001–0xA004 in order, with `ext_out_data` held stable while not accepted.
- Simultaneous push and pop:
  - With the input FIFO holding 2 words, push and pop on the same edge -> count stays 2.
  - On an empty FIFO, `cpu_rd` together with a push of 0xBEEF -> `err_underflow`=1 and 0xBEEF appears on `read_in` next cycle.
- Wrap-around: stream 10 words 0x0000–0x0009 through each FIFO, with continuous push and one-cycle-delayed pop -> all 10 arrive in order and counts never exceed 2.
- Error flag clear: raise `err_underflow`, then pulse `err_clr` alone -> flag clears next edge. Pulse `err_clr` together with a new `cpu_rd` on the empty FIFO -> flag stays 1.
